macrocell_bank: RTL and testbench



---
 rtl/mc_bank_pkg.sv | 39 +++
 rtl/macrocell_slice.sv | 69 ++++++
 rtl/macrocell_bank.sv | 143 ++++++++++++++
 tb/tb_macrocell_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mc_bank_pkg.sv
// Shared definitions for the macrocell bank: config word layout, OE select
// encodings and loader states.
package mc_bank_pkg;

    localparam int CFG_W = 10;

    // Field positions inside one cell's config word
    localparam int CFG_CAS_EN    = 0;
    localparam int CFG_XOR_INV   = 1;
    localparam int CFG_T_MODE    = 2;
    localparam int CFG_O_COMB    = 3;
    localparam int CFG_FB_COMB   = 4;
    localparam int CFG_PT4_CE    = 5;
    localparam int CFG_PT3_AR    = 6;
    localparam int CFG_PT5_AS    = 7;
    localparam int CFG_OE_SEL_LO = 8;
    localparam int CFG_OE_SEL_HI = 9;

    localparam logic [1:0] OE_OFF  = 2'b00;
    localparam logic [1:0] OE_ON   = 2'b01;
    localparam logic [1:0] OE_GOE0 = 2'b10;
    localparam logic [1:0] OE_GOE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RUN    = 2'd2
    } load_state_t;

    function automatic logic oe_decode(input logic [1:0] sel, input logic [1:0] goe);
        case (sel)
            OE_OFF:  return 1'b0;
            OE_ON:   return 1'b1;
            OE_GOE0: return goe[0];
            default: return goe[1];
        endcase
    endfunction

endpackage

// File: rtl/macrocell_slice.sv
// One macrocell: product-term sum with cascade, XOR invert, D/T flop with
// synchronous reset/set/clock-enable terms, and pad/feedback/OE muxes.
module macrocell_slice
    import mc_bank_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       pt,
    input  logic             casin,
    input  logic [CFG_W-1:0] cfg,
    input  logic [1:0]       goe,
    input  logic             cfg_ready,
    input  logic             clr,
    output logic             pad,
    output logic             pad_oe,
    output logic             fb,
    output logic             cas_out
);

    logic sum_raw;
    logic sum_own;
    logic x;
    logic ar_hit;
    logic as_hit;
    logic hold;
    logic q_reg;
    logic q_next;

    // pt3/pt4/pt5 are stolen from the sum when used as control terms
    assign sum_raw = pt[0] | pt[1]
                   | (pt[2] & ~cfg[CFG_PT3_AR])
                   | (pt[3] & ~cfg[CFG_PT4_CE])
                   | (pt[4] & ~cfg[CFG_PT5_AS])
                   | casin;

    assign cas_out = cfg[CFG_CAS_EN] & sum_raw;
    assign sum_own = ~cfg[CFG_CAS_EN] & sum_raw;
    assign x       = sum_own ^ cfg[CFG_XOR_INV];

    assign ar_hit = pt[2] & cfg[CFG_PT3_AR];
    assign as_hit = pt[4] & cfg[CFG_PT5_AS];
    assign hold   = cfg[CFG_PT4_CE] & ~pt[3];

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = 1'b0;
        end else if (ar_hit) begin
            q_next = 1'b0;
        end else if (as_hit) begin
            q_next = 1'b1;
        end else if (!hold) begin
            q_next = cfg[CFG_T_MODE] ? (q_reg ^ x) : x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign pad    = cfg[CFG_O_COMB]  ? x : q_reg;
    assign fb     = cfg[CFG_FB_COMB] ? x : q_reg;
    assign pad_oe = cfg_ready & oe_decode(cfg[CFG_OE_SEL_HI:CFG_OE_SEL_LO], goe);

endmodule

// File: rtl/macrocell_bank.sv
// Bank of MC_COUNT macrocells with a serial shadow/active config loader.
// Define MC_CFG_READBACK_EN to expose the shadow chain MSB on cfg_out_v.
module macrocell_bank
    import mc_bank_pkg::*;
#(
    parameter int MC_COUNT  = 4,
    parameter int PT_PER_MC = 5
) (
    input  logic                      clk_v,
    input  logic                      rst_n_v,
    input  logic [MC_COUNT*PT_PER_MC-1:0] pt_v,
    input  logic                      casin_v,
    input  logic [1:0]                goe_v,
    input  logic                      cfg_en_v,
    input  logic                      cfg_bit_v,
    input  logic                      cfg_commit_v,
    output logic [MC_COUNT-1:0]       pad_v,
    output logic [MC_COUNT-1:0]       pad_oe_v,
    output logic [MC_COUNT-1:0]       mc_fb_v,
    output logic                      casout_v,
    output logic                      cfg_ready_v,
    output logic                      cfg_err_v,
    output logic                      cfg_out_v
);

    localparam int TOT   = MC_COUNT * CFG_W;
    localparam int CNT_W = $clog2(TOT + 2);
    localparam logic [CNT_W-1:0] CNT_TOT = CNT_W'(TOT);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TOT + 1);

    load_state_t      state_reg;
    load_state_t      state_next;
    logic [TOT-1:0]   shadow_reg;
    logic [TOT-1:0]   active_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             cfg_ready_reg;
    logic             cfg_err_reg;
    logic             shift_en;
    logic             cnt_clear;
    logic             do_commit;
    logic             do_reject;
    logic [MC_COUNT:0] cas_chain;

    always_ff @(posedge clk_v or negedge rst_n_v) begin
        if (!rst_n_v) begin
            state_reg <= ST_UNCONF;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        cnt_clear  = 1'b0;
        do_commit  = 1'b0;
        do_reject  = 1'b0;
        case (state_reg)
            ST_UNCONF, ST_RUN: begin
                if (cfg_en_v) begin
                    state_next = ST_SHIFT;
                    shift_en   = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cfg_en_v) begin
                    shift_en = 1'b1;
                end else if (cfg_commit_v) begin
                    if (cnt_reg == CNT_TOT) begin
                        do_commit  = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        // A valid active config implies we came from RUN
                        do_reject  = 1'b1;
                        state_next = cfg_ready_reg ? ST_RUN : ST_UNCONF;
                    end
                end
            end
            default: state_next = ST_UNCONF;
        endcase
    end

    always_ff @(posedge clk_v or negedge rst_n_v) begin
        if (!rst_n_v) begin
            shadow_reg    <= '0;
            active_reg    <= '0;
            cnt_reg       <= '0;
            cfg_ready_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow_reg <= {shadow_reg[TOT-2:0], cfg_bit_v};
            end
            // The entry cycle already shifts one bit, so the count restarts at 1
            if (cnt_clear) begin
                cnt_reg <= CNT_W'(1);
            end else if (shift_en && (cnt_reg != CNT_SAT)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (do_commit) begin
                active_reg    <= shadow_reg;
                cfg_ready_reg <= 1'b1;
                cfg_err_reg   <= 1'b0;
            end
            if (do_reject) begin
                cfg_err_reg <= 1'b1;
            end
        end
    end

    assign cas_chain[0] = casin_v;

    generate
        for (genvar gi = 0; gi < MC_COUNT; gi++) begin : g_cell
            macrocell_slice u_slice (
                .clk       (clk_v),
                .rst_n     (rst_n_v),
                .pt        (pt_v[gi*PT_PER_MC +: PT_PER_MC]),
                .casin     (cas_chain[gi]),
                .cfg       (active_reg[gi*CFG_W +: CFG_W]),
                .goe       (goe_v),
                .cfg_ready (cfg_ready_reg),
                .clr       (do_commit),
                .pad       (pad_v[gi]),
                .pad_oe    (pad_oe_v[gi]),
                .fb        (mc_fb_v[gi]),
                .cas_out   (cas_chain[gi+1])
            );
        end
    endgenerate

    assign casout_v    = cas_chain[MC_COUNT];
    assign cfg_ready_v = cfg_ready_reg;
    assign cfg_err_v   = cfg_err_reg;

`ifdef MC_CFG_READBACK_EN
    assign cfg_out_v = shadow_reg[TOT-1];
`else
    assign cfg_out_v = 1'b0;
`endif

endmodule

// File: tb/tb_macrocell_bank.sv
// Directed bench for macrocell_bank (MC_COUNT=4): loader accept/reject,
// D/T flop behaviour, cascade, and reconfiguration while running.
module tb_macrocell_bank;

    localparam int MC  = 4;
    localparam int TOT = 40;

    // Per-cell words, cell 3 in the high bits
    localparam logic [47:0] ONES_WORD = {8'h00, 40'hFF_FFFF_FFFF};
    localparam logic [47:0] A_WORD    = {8'h00, 10'h100, 10'h100, 10'h1C4, 10'h100};
    localparam logic [47:0] B_WORD    = {8'h00, 10'h101, 10'h20A, 10'h118, 10'h101};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [MC*5-1:0] pt;
    logic          casin;
    logic [1:0]    goe;
    logic          cfg_en;
    logic          cfg_bit;
    logic          cfg_commit;
    logic [MC-1:0] pad;
    logic [MC-1:0] pad_oe;
    logic [MC-1:0] mc_fb;
    logic          casout;
    logic          cfg_ready;
    logic          cfg_err;
    logic          cfg_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    macrocell_bank #(.MC_COUNT(MC), .PT_PER_MC(5)) dut (
        .clk_v        (clk),
        .rst_n_v      (rst_n),
        .pt_v         (pt),
        .casin_v      (casin),
        .goe_v        (goe),
        .cfg_en_v     (cfg_en),
        .cfg_bit_v    (cfg_bit),
        .cfg_commit_v (cfg_commit),
        .pad_v        (pad),
        .pad_oe_v     (pad_oe),
        .mc_fb_v      (mc_fb),
        .casout_v     (casout),
        .cfg_ready_v  (cfg_ready),
        .cfg_err_v    (cfg_err),
        .cfg_out_v    (cfg_out)
    );

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift nbits of word MSB first, then commit. Optionally check the
    // readback stream against old_word and that cell 1 still follows pt[0].
    task automatic load_cfg(input logic [47:0] word, input int nbits,
                            input logic [47:0] old_word, input bit chk_old,
                            input bit chk_run);
        for (int k = 0; k < nbits; k++) begin
            cfg_en  = 1'b1;
            cfg_bit = word[nbits-1-k];
            if (chk_run) pt[0] = k[0];
            #1;
            if (chk_old) begin
`ifdef MC_CFG_READBACK_EN
                check("readback_old", cfg_out, old_word[TOT-1-k]);
`else
                check("cfg_out_tied0", cfg_out, old_word[TOT-1-k] & 1'b0);
`endif
            end
            if (chk_run) check("run_old_cfg_pad1", pad[1], pt[0]);
            step();
        end
        cfg_en     = 1'b0;
        cfg_bit    = 1'b0;
        cfg_commit = 1'b1;
        if (chk_run) pt[0] = 1'b0;
        step();
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pt = '0; casin = 1'b0; goe = 2'b11;
        cfg_en = 1'b0; cfg_bit = 1'b0; cfg_commit = 1'b0;
        step(); step();
        check("rst_pad", pad, 4'h0);
        check("rst_pad_oe", pad_oe, 4'h0);
        check("rst_fb", mc_fb, 4'h0);
        check("rst_casout", casout, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_cfg_out", cfg_out, 1'b0);
        rst_n = 1'b1;
        step();

        // Short load from UNCONF is rejected
        load_cfg(ONES_WORD, TOT-1, '0, 1'b0, 1'b0);
        check("short_err", cfg_err, 1'b1);
        check("short_ready", cfg_ready, 1'b0);
        check("short_oe", pad_oe, 4'h0);

        // Full load of all ones: OE follows goe[1]
        load_cfg(ONES_WORD, TOT, '0, 1'b0, 1'b0);
        check("ones_ready", cfg_ready, 1'b1);
        check("ones_err", cfg_err, 1'b0);
        goe = 2'b10; #1;
        check("ones_oe_goe1_hi", pad_oe, 4'hF);
        goe = 2'b01; #1;
        check("ones_oe_goe1_lo", pad_oe, 4'h0);

        // Over-long load from RUN is rejected, active config kept
        load_cfg('0, TOT+1, '0, 1'b0, 1'b0);
        check("long_err", cfg_err, 1'b1);
        check("long_ready", cfg_ready, 1'b1);
        goe = 2'b10; #1;
        check("long_oe_kept", pad_oe, 4'hF);

        // Config A: cell 0 D registered, cell 1 T with ar/as
        load_cfg(A_WORD, TOT, '0, 1'b0, 1'b0);
        check("a_err_cleared", cfg_err, 1'b0);
        check("a_oe_on", pad_oe, 4'hF);
        check("a_pad_cleared", pad, 4'h0);
        pt[0] = 1'b1; #1;
        check("d_before_edge", pad[0], 1'b0);
        step(); pt[0] = 1'b0; #1;
        check("d_one_cycle", pad[0], 1'b1);
        step();
        check("d_back_low", pad[0], 1'b0);

        pt[5] = 1'b1;
        step(); check("t_toggle1", pad[1], 1'b1);
        step(); check("t_toggle2", pad[1], 1'b0);
        step(); check("t_toggle3", pad[1], 1'b1);
        step(); check("t_toggle4", pad[1], 1'b0);
        step(); check("t_set_up", pad[1], 1'b1);
        pt[5] = 1'b0; pt[7] = 1'b1; pt[9] = 1'b1;
        step(); check("ar_wins", pad[1], 1'b0);
        check("ar_wins_fb", mc_fb[1], 1'b0);
        pt[7] = 1'b0;
        step(); check("as_sets", pad[1], 1'b1);
        pt = '0;
        step();

        // Config B: cell 0 cascades into combinational cell 1
        load_cfg(B_WORD, TOT, '0, 1'b0, 1'b0);
        goe = 2'b01; #1;
        check("b_idle_pad", pad, 4'h4);
        check("b_oe_goe0_hi", pad_oe, 4'hF);
        goe = 2'b00; #1;
        check("b_oe_goe0_lo", pad_oe, 4'hB);
        pt[0] = 1'b1; #1;
        check("cas_pad", pad, 4'h6);
        check("cas_fb1", mc_fb[1], 1'b1);
        check("cas_casout_lo", casout, 1'b0);
        step();
        check("cas_src_flop_0", pad[0], 1'b0);
        pt[0] = 1'b0; casin = 1'b1; #1;
        check("casin_to_cell1", pad[1], 1'b1);
        check("casin_no_casout", casout, 1'b0);
        pt[15] = 1'b1; #1;
        check("casout_hi", casout, 1'b1);
        pt = '0; casin = 1'b0; #1;
        check("casout_lo", casout, 1'b0);
        step();

        // Reload A while running on B
        load_cfg(A_WORD, TOT, B_WORD, 1'b1, 1'b1);
        check("reload_ready", cfg_ready, 1'b1);
        check("reload_flops_cleared", pad, 4'h0);
        check("reload_oe", pad_oe, 4'hF);
        step();
        check("reload_steady", pad, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
